// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the WIDTH-bit add is split into STAGES ripple
// chunks, each chunk registered with its carry and the operand bits still to be added.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("pipe_addsub: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] carry_r;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] up_valid_s;
  logic [STAGES-1:0] ncarry_s;
  logic [WIDTH-1:0]  psum_r  [STAGES];
  logic [WIDTH-1:0]  opa_r   [STAGES];
  logic [WIDTH-1:0]  opb_r   [STAGES];
  logic [WIDTH-1:0]  nsum_s  [STAGES];
  logic [WIDTH-1:0]  nopa_s  [STAGES];
  logic [WIDTH-1:0]  nopb_s  [STAGES];
  logic              vflag_s [STAGES];
  logic [WIDTH-1:0]  b_eff_s;
  logic              nz_s;
  logic              flag_z_r;
  logic              flag_v_r;

  assign b_eff_s    = b ^ {WIDTH{sub}};
  assign up_valid_s = (valid_r << 1) | STAGES'(in_valid);

  // Operand words are kept right-aligned: each stage consumes the low chunk
  // and hands the remainder, shifted down, to the next stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] ca_s;
    logic [CHUNK-1:0] cb_s;
    logic [CHUNK-1:0] csum_s;
    logic             cin_s;
    logic             cout_s;
    logic [WIDTH-1:0] prev_sum_s;
    logic [WIDTH-1:0] rem_a_s;
    logic [WIDTH-1:0] rem_b_s;

    if (k == 0) begin : g_first
      assign rem_a_s    = a;
      assign rem_b_s    = b_eff_s;
      assign cin_s      = sub;
      assign prev_sum_s = '0;
    end else begin : g_next
      assign rem_a_s    = opa_r[k-1];
      assign rem_b_s    = opb_r[k-1];
      assign cin_s      = carry_r[k-1];
      assign prev_sum_s = psum_r[k-1];
    end

    assign ca_s             = rem_a_s[CHUNK-1:0];
    assign cb_s             = rem_b_s[CHUNK-1:0];
    assign {cout_s, csum_s} = {1'b0, ca_s} + {1'b0, cb_s} + {{CHUNK{1'b0}}, cin_s};
    assign ncarry_s[k]      = cout_s;
    assign nsum_s[k]        = prev_sum_s | (WIDTH'(csum_s) << (k * CHUNK));
    assign nopa_s[k]        = rem_a_s >> CHUNK;
    assign nopb_s[k]        = rem_b_s >> CHUNK;
    assign vflag_s[k]       = (ca_s[CHUNK-1] == cb_s[CHUNK-1]) && (csum_s[CHUNK-1] != ca_s[CHUNK-1]);
  end

  // Backpressure chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv_s       = '0;
    adv_s[LAST] = !valid_r[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv_s[k] = !valid_r[k] || adv_s[k+1];
    end
  end

  assign in_ready = !valid_r[0] || adv_s[0];
  assign nz_s     = (nsum_s[LAST] == '0);

  // Pipeline registers; data only loads with a real operation so outputs stay put across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= '0;
      carry_r  <= '0;
      flag_z_r <= 1'b0;
      flag_v_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        psum_r[k] <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          valid_r[k] <= up_valid_s[k];
          if (up_valid_s[k]) begin
            psum_r[k]  <= nsum_s[k];
            carry_r[k] <= ncarry_s[k];
            opa_r[k]   <= nopa_s[k];
            opb_r[k]   <= nopb_s[k];
          end
        end
      end
      if (adv_s[LAST] && up_valid_s[LAST]) begin
        flag_z_r <= nz_s;
        flag_v_r <= vflag_s[LAST];
      end
    end
  end

  assign out_valid = valid_r[LAST];
  assign sum       = psum_r[LAST];
  assign flag_n    = psum_r[LAST][WIDTH-1];
  assign flag_z    = flag_z_r;
  assign flag_c    = carry_r[LAST];
  assign flag_v    = flag_v_r;

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  the operand set on a, b, sub is valid.
REQ-007 SHALL have port in_ready  output  1  the block accepts an operand set this cycle.
REQ-008 SHALL have port a  input  WIDTH  first operand.
REQ-009 SHALL have port b  input  WIDTH  second operand.
REQ-010 SHALL have port sub  input  1  0 = a+b; 1 = a-b.
REQ-011 SHALL have port out_valid  output  1  result and flags are valid.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port flag_n  output  1  sum[WIDTH-1].
REQ-015 SHALL have port flag_z  output  1  sum == 0.
REQ-016 SHALL have port flag_c  output  1  carry out; for sub this is NOT borrow (ARM convention).
REQ-017 SHALL have port flag_v  output  1  signed two's-complement overflow.

Function
REQ-018 SHALL compute a + (b XOR {WIDTH{sub}}) + sub with ripple-carry chunks: stage k (k = 0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1; stage 0 takes carry-in = sub.
REQ-019 SHALL register the not-yet-consumed upper operand chunks alongside each stage, with one valid bit per stage.
REQ-020 SHALL accept an operation when in_valid && in_ready at a rising edge.
REQ-021 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
REQ-022 SHALL sustain one accepted operation per cycle while out_ready is high.
REQ-023 SHALL advance stage k when it is empty or stage k+1 advances; the last stage advances when out_ready is high or out_valid is low.
REQ-024 SHALL assert in_ready = !valid[0] || advance[0] combinationally, so that bubbles collapse while the output is stalled.
REQ-025 SHALL hold sum and all flags stable while out_valid && !out_ready.
REQ-026 SHALL complete results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-027 SHALL compute flag_v = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted b when sub = 1.
REQ-028 SHALL compute flag_c as the carry out of bit WIDTH-1.
REQ-029 SHALL compute flag_z over the full WIDTH result, not per chunk.
REQ-030 SHALL, on flush at a rising edge, clear all stage valid bits, deassert out_valid next cycle, and accept no operand in that cycle (in_ready is don't-care while flush is high).
REQ-031 SHALL give reset priority over flush, and flush priority over acceptance.
REQ-032 SHALL, for STAGES = 1, reduce to a single registered adder with a latency of 1.

Reset
REQ-033 SHALL, while reset is high at a rising edge, clear all valid bits; from the next cycle out_valid = 0, sum = 0, and all flags = 0.
REQ-034 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-035 SHALL discard operations in flight when reset asserts mid-operation; none of them appear at the output.
REQ-036 SHALL allow datapath registers other than the output and valid bits to be left unreset.

Verification (WIDTH=32, STAGES=4)
REQ-037 SHALL cover: a=0xFFFFFFFF, b=1, sub=0, out_ready=1 -> after 4 cycles sum=0, Z=1, C=1, V=0, N=0 (carry ripples through every chunk).
REQ-038 SHALL cover: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, N=1, V=1, C=0; and a=5, b=7, sub=1 -> sum=0xFFFFFFFE, N=1, C=0, V=0.
REQ-039 SHALL cover: back-to-back stream of 8 random ops with out_ready=1 -> one result per cycle, in order, first result 4 cycles after the first acceptance.
REQ-040 SHALL cover: output stalled (out_ready=0) for 6 cycles with in_valid=1 -> exactly 4 ops accepted, in_ready=0 after that, and sum held stable; on release all results drain in order.
REQ-041 SHALL cover: flush asserted with 3 ops in flight -> out_valid=0 next cycle, no flushed result ever appears, and the next accepted op completes in 4 cycles.
REQ-042 SHALL cover: reset asserted mid-stream -> out_valid=0 and sum=0 next cycle, and in_ready=1 the cycle after reset deasserts.
